// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM multicycle controller.
// The optional extended ALU commands are enabled with the ARM_CTRL_EXT_ALU_EN macro.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // ALU operation codes (three bits so the extended EOR code fits)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Instruction class (IR[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // Data-processing command field (funct[4:1]) to ALU operation
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    logic [2:0] code;
    case (cmd)
      4'b0100: code = ALU_ADD;
      4'b0010: code = ALU_SUB;
      4'b0000: code = ALU_AND;
      4'b1100: code = ALU_ORR;
`ifdef ARM_CTRL_EXT_ALU_EN
      4'b0001: code = ALU_EOR;
      4'b1010: code = ALU_SUB;
`endif
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// Combinational ARM condition-code evaluator against NZCV flags.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n_f, z_f, c_f, v_f, ge;

  assign {n_f, z_f, c_f, v_f} = flags;
  assign ge = (n_f == v_f);

  // Evaluate the condition field; NV never executes
  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z_f;
      COND_NE: condex = ~z_f;
      COND_CS: condex = c_f;
      COND_CC: condex = ~c_f;
      COND_MI: condex = n_f;
      COND_PL: condex = ~n_f;
      COND_VS: condex = v_f;
      COND_VC: condex = ~v_f;
      COND_HI: condex = c_f & ~z_f;
      COND_LS: condex = ~(c_f & ~z_f);
      COND_GE: condex = ge;
      COND_LT: condex = ~ge;
      COND_GT: condex = ~z_f & ge;
      COND_LE: condex = ~(~z_f & ge);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM controller: FETCH/DECODE/EXECUTE/WRITEBACK sequencing with
// conditional execution and an internal NZCV register.
// Define ARM_CTRL_EXT_ALU_EN to add EOR and CMP commands (requires ALUCTRL_W >= 3).
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 2,
  parameter int COND_EXEC     = 1,
  parameter int TRAP_ON_UNDEF = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           cond,
  input  logic [1:0]           op,
  input  logic [5:0]           funct,
  input  logic [3:0]           rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic                 Illegal
);

`ifdef ARM_CTRL_EXT_ALU_EN
  generate
    if (ALUCTRL_W < 3) begin : g_width_check
      $error("arm_multicycle_ctrl: ALUCTRL_W must be >= 3 with extended ALU commands");
    end
  endgenerate
`endif

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  logic       cond_ok;

  logic       next_pc, branch, reg_w, mem_w, ir_w;
  logic [2:0] alu_op;
  logic [2:0] cmd_alu;
  logic       is_cmp;
  logic       is_rd_pc;

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags_q),
    .condex (cond_ok)
  );

  assign cmd_alu  = alu_decode(funct[4:1]);
  assign is_rd_pc = (rd == 4'hF);
`ifdef ARM_CTRL_EXT_ALU_EN
  assign is_cmp = (funct[4:1] == 4'b1010);
`else
  assign is_cmp = 1'b0;
`endif

  // State, flag and condition latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Next-state and per-state datapath control decode
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    condex_d  = condex_q;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ImmSrc    = 2'b00;
    RegSrc    = 2'b00;
    alu_op    = ALU_ADD;
    Illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_w      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next_pc   = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ImmSrc    = (op == OP_UND) ? 2'b00 : op;
        RegSrc    = {(op == OP_MEM) & ~funct[0], (op == OP_BR)};
        // Condition is resolved here so an EXECUTE flag update cannot
        // change this instruction's own writeback.
        condex_d  = (COND_EXEC != 0) ? cond_ok : 1'b1;
        case (op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        alu_op  = cmd_alu;
        if (condex_q && (funct[0] || is_cmp)) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (cmd_alu == ALU_ADD || cmd_alu == ALU_SUB)
            flags_d[1:0] = ALUFlags[1:0];
        end
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = ~is_cmp;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      UNKNOWN: begin
        Illegal = 1'b1;
        state_d = (TRAP_ON_UNDEF != 0) ? UNKNOWN : FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables are conditioned and held off during the reset cycle
  assign MemWrite   = ~reset & mem_w & condex_q;
  assign RegWrite   = ~reset & reg_w & condex_q & ~is_rd_pc;
  assign PCWrite    = ~reset & (next_pc | (condex_q & (branch | (reg_w & is_rd_pc))));
  assign IRWrite    = ~reset & ir_w;
  assign ALUControl = ALUCTRL_W'(alu_op);
  assign Flags      = flags_q;

endmodule
